hex_display_arbiter: RTL and testbench

//   Shares the single 2-digit hex display (display_hex_byte) between NUM_REQ

---
 rtl/hex_display_arbiter_if.sv | 26 ++
 rtl/hex_display_arbiter.sv | 122 ++++++++++++
 tb/tb_hex_display_arbiter.sv | 211 +++++++++++++++++++++
 3 files changed

// File: rtl/hex_display_arbiter_if.sv
// rtl/hex_display_arbiter_if.sv - requester/display bundle for the hex display arbiter
interface hex_display_arbiter_if #(
  parameter int NUM_REQ = 4
);
  localparam int IW = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0]   req;
  logic [8*NUM_REQ-1:0] req_data;
  logic [NUM_REQ-1:0]   grant;
  logic [NUM_REQ-1:0]   ack;
  logic [7:0]           hex_byte;
  logic [IW-1:0]        src_idx;
  logic                 busy;

  // requester side: raises requests and watches grant/ack
  modport master (
    output req, req_data,
    input  grant, ack, hex_byte, src_idx, busy
  );

  // arbiter side
  modport slave (
    input  req, req_data,
    output grant, ack, hex_byte, src_idx, busy
  );
endinterface

// File: rtl/hex_display_arbiter.sv
// rtl/hex_display_arbiter.sv - round-robin sharing of one 2-digit hex display
module hex_display_arbiter #(
  parameter int         NUM_REQ      = 4,
  parameter int         DWELL_CYCLES = 50000000,
  parameter logic [7:0] IDLE_BYTE    = 8'h00
) (
  input  logic               clk,
  input  logic               rst,
  hex_display_arbiter_if.slave bus
);
  localparam int          IW         = $clog2(NUM_REQ);
  localparam logic [31:0] DWELL_LAST = 32'(DWELL_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, SHOW, ACK} state_t;

  state_t             state_q, state_nxt;
  logic [NUM_REQ-1:0] grant_q, grant_nxt;
  logic [NUM_REQ-1:0] ack_q, ack_nxt;
  logic [7:0]         hex_q, hex_nxt;
  logic [IW-1:0]      src_q, src_nxt;
  logic [IW-1:0]      last_q, last_nxt;
  logic               busy_q, busy_nxt;
  logic [31:0]        cnt_q, cnt_nxt;

  logic               win_valid;
  logic [IW-1:0]      win_idx;
  logic [IW-1:0]      cand;
  int                 pos;

  // Round-robin search starting just after the last winner; scanning from the
  // far end backwards leaves the nearest requester as the final assignment.
  always_comb begin
    win_valid = 1'b0;
    win_idx   = '0;
    cand      = '0;
    pos       = 0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      pos  = (int'(last_q) + k) % NUM_REQ;
      cand = IW'(pos);
      if (bus.req[cand]) begin
        win_valid = 1'b1;
        win_idx   = cand;
      end
    end
  end

  // Next-state and next-output logic; every output is registered below.
  always_comb begin
    state_nxt = state_q;
    grant_nxt = grant_q;
    ack_nxt   = ack_q;
    hex_nxt   = hex_q;
    src_nxt   = src_q;
    last_nxt  = last_q;
    busy_nxt  = busy_q;
    cnt_nxt   = cnt_q;
    case (state_q)
      IDLE: begin
        if (win_valid) begin
          state_nxt          = SHOW;
          grant_nxt          = '0;
          grant_nxt[win_idx] = 1'b1;
          busy_nxt           = 1'b1;
          src_nxt            = win_idx;
          last_nxt           = win_idx;
          hex_nxt            = bus.req_data[{win_idx, 3'b000} +: 8];
          cnt_nxt            = '0;
        end
      end
      SHOW: begin
        if (cnt_q == DWELL_LAST) begin
          state_nxt = ACK;
          grant_nxt = '0;
          ack_nxt   = grant_q;
        end else begin
          cnt_nxt = cnt_q + 32'd1;
        end
      end
      ACK: begin
        state_nxt = IDLE;
        ack_nxt   = '0;
        busy_nxt  = 1'b0;
      end
      default: begin
        state_nxt = IDLE;
        grant_nxt = '0;
        ack_nxt   = '0;
        busy_nxt  = 1'b0;
      end
    endcase
  end

  // State and output registers; reset leaves the pointer on the top requester
  // so requester 0 wins the first arbitration.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      grant_q <= '0;
      ack_q   <= '0;
      hex_q   <= IDLE_BYTE;
      src_q   <= '0;
      last_q  <= IW'(NUM_REQ - 1);
      busy_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_nxt;
      grant_q <= grant_nxt;
      ack_q   <= ack_nxt;
      hex_q   <= hex_nxt;
      src_q   <= src_nxt;
      last_q  <= last_nxt;
      busy_q  <= busy_nxt;
      cnt_q   <= cnt_nxt;
    end
  end

  assign bus.grant    = grant_q;
  assign bus.ack      = ack_q;
  assign bus.hex_byte = hex_q;
  assign bus.src_idx  = src_q;
  assign bus.busy     = busy_q;
endmodule

// File: tb/tb_hex_display_arbiter.sv
// tb/tb_hex_display_arbiter.sv - self-checking bench for hex_display_arbiter
module tb_hex_display_arbiter;
  logic clk;
  logic rst;
  int   checks;
  int   errors;
  int   cyc;

  hex_display_arbiter_if #(.NUM_REQ(4)) bus ();

  hex_display_arbiter #(
    .NUM_REQ(4),
    .DWELL_CYCLES(5),
    .IDLE_BYTE(8'hEE)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  typedef struct packed {
    logic        rst;
    logic [3:0]  req;
    logic [31:0] data;
    logic [3:0]  grant;
    logic [3:0]  ack;
    logic [7:0]  hex;
    logic [1:0]  src;
    logic        busy;
  } vec_t;

  vec_t vecs [11];

  // free-running clock, 10 time units per period
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // cycle counter used to measure grant-to-grant period
  always @(posedge clk) cyc <= cyc + 1;

  // grant and ack must stay one-hot and never overlap
  always @(negedge clk) begin
    if (!rst) begin
      checks++;
      if ((bus.grant & bus.ack) != 4'h0 || !$onehot0(bus.grant) || !$onehot0(bus.ack)) begin
        errors++;
        $display("FAIL exclusive: grant=%b ack=%b at cycle %0d", bus.grant, bus.ack, cyc);
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    bus.req = 4'h0;
    bus.req_data = 32'h0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Follows one full grant: mode 1 changes the granted byte mid-dwell,
  // mode 2 drops the request mid-dwell. Leaves the caller one edge after ack.
  task automatic run_grant(input int idx, input logic [7:0] b, input int mode, output int start_cyc);
    int n;
    int len;
    int hex_bad;
    n = 0;
    len = 0;
    hex_bad = 0;
    start_cyc = -1;
    while (bus.grant == 4'h0 && n < 30) begin
      @(posedge clk); #1;
      n++;
    end
    chk("grant_seen", 32'(bus.grant != 4'h0), 32'd1);
    start_cyc = cyc;
    chk("grant_idx", 32'(bus.grant), 32'(4'b0001 << idx));
    chk("src_idx", 32'(bus.src_idx), 32'(idx));
    chk("busy_show", 32'(bus.busy), 32'd1);
    while (bus.grant != 4'h0 && len < 30) begin
      if (bus.hex_byte !== b) hex_bad++;
      len++;
      if (len == 2 && mode == 1) bus.req_data[8*idx +: 8] = 8'h5A;
      if (len == 2 && mode == 2) bus.req[idx] = 1'b0;
      @(posedge clk); #1;
    end
    chk("dwell_len", 32'(len), 32'd5);
    chk("hex_stable", 32'(hex_bad), 32'd0);
    chk("ack_pulse", 32'(bus.ack), 32'(4'b0001 << idx));
    chk("busy_ack", 32'(bus.busy), 32'd1);
    @(posedge clk); #1;
    chk("ack_drop", 32'(bus.ack), 32'd0);
    chk("busy_idle", 32'(bus.busy), 32'd0);
    chk("hex_hold", 32'(bus.hex_byte), 32'(b));
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int s [5];
    int dummy;
    checks = 0;
    errors = 0;
    cyc = 0;
    rst = 1'b1;
    bus.req = 4'h0;
    bus.req_data = 32'h0;

    // reset/idle, then a single request on requester 2
    vecs[0]  = '{1'b1, 4'h0, 32'h0,        4'h0, 4'h0, 8'hEE, 2'd0, 1'b0};
    vecs[1]  = '{1'b0, 4'h0, 32'h0,        4'h0, 4'h0, 8'hEE, 2'd0, 1'b0};
    vecs[2]  = '{1'b0, 4'h0, 32'h0,        4'h0, 4'h0, 8'hEE, 2'd0, 1'b0};
    vecs[3]  = '{1'b0, 4'h4, 32'h003C0000, 4'h4, 4'h0, 8'h3C, 2'd2, 1'b1};
    vecs[4]  = '{1'b0, 4'h4, 32'h003C0000, 4'h4, 4'h0, 8'h3C, 2'd2, 1'b1};
    vecs[5]  = '{1'b0, 4'h4, 32'h003C0000, 4'h4, 4'h0, 8'h3C, 2'd2, 1'b1};
    vecs[6]  = '{1'b0, 4'h4, 32'h003C0000, 4'h4, 4'h0, 8'h3C, 2'd2, 1'b1};
    vecs[7]  = '{1'b0, 4'h4, 32'h003C0000, 4'h4, 4'h0, 8'h3C, 2'd2, 1'b1};
    vecs[8]  = '{1'b0, 4'h0, 32'h0,        4'h0, 4'h4, 8'h3C, 2'd2, 1'b1};
    vecs[9]  = '{1'b0, 4'h0, 32'h0,        4'h0, 4'h0, 8'h3C, 2'd2, 1'b0};
    vecs[10] = '{1'b0, 4'h0, 32'h0,        4'h0, 4'h0, 8'h3C, 2'd2, 1'b0};

    for (int i = 0; i < 11; i++) begin
      @(negedge clk);
      rst = vecs[i].rst;
      bus.req = vecs[i].req;
      bus.req_data = vecs[i].data;
      @(posedge clk); #1;
      chk($sformatf("v%0d_grant", i), 32'(bus.grant), 32'(vecs[i].grant));
      chk($sformatf("v%0d_ack", i), 32'(bus.ack), 32'(vecs[i].ack));
      chk($sformatf("v%0d_hex", i), 32'(bus.hex_byte), 32'(vecs[i].hex));
      chk($sformatf("v%0d_src", i), 32'(bus.src_idx), 32'(vecs[i].src));
      chk($sformatf("v%0d_busy", i), 32'(bus.busy), 32'(vecs[i].busy));
    end

    // all requesters held: order 0,1,2,3,0 with a 7-cycle period
    do_reset();
    bus.req_data = 32'h44332211;
    bus.req = 4'hF;
    run_grant(0, 8'h11, 0, s[0]);
    run_grant(1, 8'h22, 0, s[1]);
    run_grant(2, 8'h33, 0, s[2]);
    run_grant(3, 8'h44, 0, s[3]);
    run_grant(0, 8'h11, 0, s[4]);
    for (int i = 1; i < 5; i++) chk($sformatf("period_%0d", i), 32'(s[i] - s[i-1]), 32'd7);

    // byte latched: data change during dwell is ignored
    do_reset();
    bus.req_data = 32'h0000A500;
    bus.req = 4'h2;
    run_grant(1, 8'hA5, 1, dummy);
    bus.req = 4'h0;

    // request dropped mid-dwell: full dwell and ack still happen
    do_reset();
    bus.req_data = 32'h7E000000;
    bus.req = 4'h8;
    run_grant(3, 8'h7E, 2, dummy);
    bus.req = 4'h0;

    // reset during SHOW cycle 3 drops grant at once; priority pointer restarts
    do_reset();
    bus.req_data = 32'h99770000;
    bus.req = 4'h4;
    @(posedge clk); #1;
    chk("rst_pre_grant", 32'(bus.grant), 32'h4);
    @(posedge clk); #1;
    @(posedge clk); #1;
    #2;
    rst = 1'b1;
    #1;
    chk("rst_async_grant", 32'(bus.grant), 32'h0);
    chk("rst_async_ack", 32'(bus.ack), 32'h0);
    chk("rst_async_busy", 32'(bus.busy), 32'h0);
    chk("rst_async_hex", 32'(bus.hex_byte), 32'hEE);
    chk("rst_async_src", 32'(bus.src_idx), 32'h0);
    @(negedge clk);
    bus.req = 4'h8;
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    chk("post_rst_grant", 32'(bus.grant), 32'h8);
    chk("post_rst_hex", 32'(bus.hex_byte), 32'h99);
    chk("post_rst_ack", 32'(bus.ack), 32'h0);

    // after reset with req 1 and 3 pending, requester 1 is searched first
    do_reset();
    bus.req_data = 32'h55005500;
    bus.req = 4'hA;
    @(posedge clk); #1;
    chk("rr_after_rst", 32'(bus.grant), 32'h2);
    chk("rr_after_rst_src", 32'(bus.src_idx), 32'd1);
    bus.req = 4'h0;
    repeat (8) @(posedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
